// File: rtl/pwm_move_seq_if.sv
// Move-command handshake bundle between a command source and pwm_move_seq.
interface pwm_move_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_ch;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic [31:0] cmd_period;
    logic [31:0] cmd_duty;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_dir,
        output cmd_steps,
        output cmd_period,
        output cmd_duty,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_dir,
        input  cmd_steps,
        input  cmd_period,
        input  cmd_duty,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_move_seq.sv
// Move sequencer: configures one channel of an 8-channel PWM generator,
// enables it, counts step pulses fed back on pwm_in, then settles and
// reports completion, abort or step timeout.
module pwm_move_seq #(
    parameter int unsigned SETTLE_CYC  = 1000,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_move_seq_if.slave  cmd,
    input  logic           abort,
    input  logic [7:0]     pwm_in,
    output logic [7:0]     en,
    output logic [7:0]     dir,
    output logic [255:0]   period_o,
    output logic [255:0]   duty_o,
    output logic           busy,
    output logic           done,
    output logic           aborted,
    output logic           timeout_err,
    output logic [15:0]    steps_done
);

    localparam int unsigned CH_W   = 3;
    localparam int unsigned STEP_W = 16;
    localparam int unsigned CFG_W  = 32;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned NCH    = 8;

    // Last count value of each phase; a zero-cycle setting still takes one cycle.
    localparam int unsigned SETTLE_LAST = (SETTLE_CYC  == 0) ? 0 : SETTLE_CYC - 1;
    localparam int unsigned TMO_LAST    = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t              state;
    state_t              next_state;

    logic                ready_q;
    logic [CH_W-1:0]     ch_q;
    logic [STEP_W-1:0]   steps_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                hist_q;

    logic                accept_c;
    logic                step_edge_c;
    logic                last_step_c;
    logic                tmo_c;
    logic                end_abort_c;

    assign cmd.cmd_ready = ready_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the per-cycle events that drive it.
    always_comb begin
        next_state  = state;
        accept_c    = (state == S_IDLE) && cmd.cmd_valid && ready_q;
        step_edge_c = (state == S_RUN) && pwm_in[ch_q] && !hist_q;
        last_step_c = step_edge_c && (STEP_W'(steps_done + STEP_W'(1)) == steps_q);
        tmo_c       = (state == S_RUN) && !step_edge_c && (cnt_q >= CNT_W'(TMO_LAST));
        end_abort_c = abort && ((state == S_LOAD) || (state == S_RUN) || (state == S_SETTLE));

        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (end_abort_c || (steps_q == '0)) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                // Abort takes priority over a coincident final step.
                if (end_abort_c) begin
                    next_state = S_DONE;
                end else if (last_step_c) begin
                    next_state = S_SETTLE;
                end else if (tmo_c) begin
                    next_state = S_DONE;
                end
            end
            S_SETTLE: begin
                if (end_abort_c || (cnt_q >= CNT_W'(SETTLE_LAST))) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            en      <= '0;
        end else begin
            ready_q <= (next_state == S_IDLE);
            busy    <= (next_state != S_IDLE);
            done    <= (next_state == S_DONE);
            en      <= (next_state == S_RUN) ? NCH'(8'd1 << ch_q) : '0;
        end
    end

    // Command capture and per-channel configuration slices.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_q     <= '0;
            steps_q  <= '0;
            dir      <= '0;
            period_o <= '0;
            duty_o   <= '0;
        end else if (accept_c) begin
            ch_q                                     <= cmd.cmd_ch;
            steps_q                                  <= cmd.cmd_steps;
            dir[cmd.cmd_ch]                          <= cmd.cmd_dir;
            period_o[{cmd.cmd_ch, 5'd0} +: CFG_W]    <= cmd.cmd_period;
            duty_o[{cmd.cmd_ch, 5'd0} +: CFG_W]      <= cmd.cmd_duty;
        end
    end

    // Edge history, shared timeout/settle counter and step counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q     <= 1'b0;
            cnt_q      <= '0;
            steps_done <= '0;
        end else begin
            hist_q <= (state == S_RUN) ? pwm_in[ch_q] : 1'b0;

            if ((next_state != state) || step_edge_c) begin
                cnt_q <= '0;
            end else if ((state == S_RUN) || (state == S_SETTLE)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if ((state == S_LOAD) && (next_state == S_RUN)) begin
                steps_done <= '0;
            end else if (step_edge_c && !end_abort_c) begin
                steps_done <= steps_done + STEP_W'(1);
            end
        end
    end

    // Completion status; cleared on accept, held through IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aborted     <= 1'b0;
            timeout_err <= 1'b0;
        end else if (accept_c) begin
            aborted     <= 1'b0;
            timeout_err <= 1'b0;
        end else if (end_abort_c) begin
            aborted     <= 1'b1;
        end else if (tmo_c) begin
            aborted     <= 1'b1;
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_move_seq.sv
// Bench for pwm_move_seq: PWM feedback model, scoreboard of expected move results.
module tb_pwm_move_seq;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 50;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         abort;
    logic [7:0]   pwm_in = '0;
    logic [7:0]   en;
    logic [7:0]   dir;
    logic [255:0] period_o;
    logic [255:0] duty_o;
    logic         busy;
    logic         done;
    logic         aborted;
    logic         timeout_err;
    logic [15:0]  steps_done;

    pwm_move_seq_if dut_if ();

    pwm_move_seq #(
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (dut_if),
        .abort       (abort),
        .pwm_in      (pwm_in),
        .en          (en),
        .dir         (dir),
        .period_o    (period_o),
        .duty_o      (duty_o),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .timeout_err (timeout_err),
        .steps_done  (steps_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ab;
        logic        te;
        logic [15:0] sd;
        logic [7:0]  en_m;
        int          gap;
        bit          from_acc;
        int          en_cycles;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc = 0, acc_cyc = 0, last_en_cyc = 0, en_cyc = 0, edges = 0, done_cnt = 0;
    logic [7:0] en_or = '0;
    bit hold_low = 1'b0;
    logic [2:0] ph [8] = '{default: 3'd0};

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(logic ab, logic te, logic [15:0] sd, logic [7:0] en_m,
                                     int gap, bit from_acc, int en_cycles);
        exp_t e;
        e.ab = ab; e.te = te; e.sd = sd; e.en_m = en_m;
        e.gap = gap; e.from_acc = from_acc; e.en_cycles = en_cycles;
        return e;
    endfunction

    // Monitor on the falling edge, then advance the PWM feedback model.
    always @(negedge clk) begin
        exp_t e;
        logic nv;
        cyc++;
        if (rst_n) begin
            if (dut_if.cmd_valid && dut_if.cmd_ready) begin
                acc_cyc = cyc; en_or = '0; en_cyc = 0; edges = 0;
            end
            if (en != 8'd0) begin
                en_or = en_or | en; en_cyc++; last_en_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("spurious_done", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("aborted", aborted, e.ab);
                    check("timeout_err", timeout_err, e.te);
                    check("steps_done", steps_done, e.sd);
                    check("en_mask", en_or, e.en_m);
                    check("done_gap", e.from_acc ? cyc - acc_cyc : cyc - last_en_cyc, e.gap);
                    if (e.en_cycles >= 0) check("en_cycles", en_cyc, e.en_cycles);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (en[k] && !hold_low) begin
                ph[k] = ph[k] + 3'd1;
                nv = ph[k][2];
            end else begin
                ph[k] = 3'd0;
                nv = 1'b0;
            end
            if (nv && !pwm_in[k]) edges++;
            pwm_in[k] = nv;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] ch, input logic d, input logic [15:0] st,
                        input logic [31:0] per, input logic [31:0] du, input exp_t e, input bit keep);
        bit hs;
        bit ok = 1'b0;
        dut_if.cmd_valid  = 1'b1;
        dut_if.cmd_ch     = ch;
        dut_if.cmd_dir    = d;
        dut_if.cmd_steps  = st;
        dut_if.cmd_period = per;
        dut_if.cmd_duty   = du;
        sb.push_back(e);
        for (int i = 0; i < 3000; i++) begin
            hs = dut_if.cmd_ready;
            step();
            if (hs) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 1'b0, 1'b1);
        if (!keep) dut_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        bit ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (sb.size() == 0 && dut_if.cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            check("idle_timeout", 1'b0, 1'b1);
            sb.delete();
        end
    endtask

    task automatic wait_edges(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (edges >= n) begin ok = 1'b1; break; end
            step();
        end
        if (!ok) check("edge_wait_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        abort = 1'b0;
        dut_if.cmd_valid  = 1'b0;
        dut_if.cmd_ch     = '0;
        dut_if.cmd_dir    = 1'b0;
        dut_if.cmd_steps  = '0;
        dut_if.cmd_period = '0;
        dut_if.cmd_duty   = '0;

        // Reset values
        repeat (3) step();
        check("rst_ready", dut_if.cmd_ready, 1'b0);
        check("rst_en", en, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_steps", steps_done, 16'd0);
        check("rst_period", period_o, 256'd0);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", dut_if.cmd_ready, 1'b1);

        // Abort while idle has no effect
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("idle_abort_busy", busy, 1'b0);
        check("idle_abort_aborted", aborted, 1'b0);

        // Normal 5-step move on channel 3
        send(3'd3, 1'b1, 16'd5, 32'd100, 32'd50, mk_exp(1'b0, 1'b0, 16'd5, 8'h08, SETTLE + 1, 1'b0, -1), 1'b0);
        check("t1_period", period_o[96 +: 32], 32'd100);
        check("t1_duty", duty_o[96 +: 32], 32'd50);
        check("t1_dir", dir, 8'h08);
        check("t1_busy", busy, 1'b1);
        check("t1_ready_low", dut_if.cmd_ready, 1'b0);
        wait_idle(2000);
        check("t1_steps_hold", steps_done, 16'd5);

        // Zero-step move: straight through LOAD to DONE
        send(3'd0, 1'b0, 16'd0, 32'd7, 32'd3, mk_exp(1'b0, 1'b0, 16'd5, 8'h00, 2, 1'b1, -1), 1'b0);
        wait_idle(100);

        // Abort after four steps on channel 7
        send(3'd7, 1'b1, 16'd10, 32'd70, 32'd35, mk_exp(1'b1, 1'b0, 16'd4, 8'h80, 1, 1'b0, -1), 1'b0);
        wait_edges(4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_idle(100);
        check("t3_steps_hold", steps_done, 16'd4);
        check("t3_aborted_hold", aborted, 1'b1);

        // Step timeout with feedback held low
        hold_low = 1'b1;
        send(3'd2, 1'b0, 16'd3, 32'd20, 32'd10, mk_exp(1'b1, 1'b1, 16'd0, 8'h04, 1, 1'b0, TIMEOUT), 1'b0);
        wait_idle(300);
        hold_low = 1'b0;
        check("t4_tmo_hold", timeout_err, 1'b1);

        // Command held valid during a move is taken only after IDLE
        send(3'd1, 1'b1, 16'd2, 32'd111, 32'd11, mk_exp(1'b0, 1'b0, 16'd2, 8'h02, SETTLE + 1, 1'b0, -1), 1'b1);
        d0 = done_cnt;
        check("t5_slice5_before", period_o[160 +: 32], 32'd0);
        send(3'd5, 1'b0, 16'd3, 32'd555, 32'd55, mk_exp(1'b0, 1'b0, 16'd3, 8'h20, SETTLE + 1, 1'b0, -1), 1'b0);
        check("t5_b_after_a_done", done_cnt, d0 + 1);
        check("t5_period1", period_o[32 +: 32], 32'd111);
        check("t5_period5", period_o[160 +: 32], 32'd555);
        check("t5_duty1", duty_o[32 +: 32], 32'd11);
        check("t5_duty5", duty_o[160 +: 32], 32'd55);
        check("t5_period3", period_o[96 +: 32], 32'd100);
        check("t5_dir", dir, 8'h8A);
        wait_idle(2000);

        // Reset in the middle of a move
        send(3'd4, 1'b1, 16'd20, 32'd44, 32'd22, mk_exp(1'b0, 1'b0, 16'd20, 8'h10, SETTLE + 1, 1'b0, -1), 1'b0);
        wait_edges(2);
        check("t6_en_running", en, 8'h10);
        d0 = done_cnt;
        rst_n = 1'b0;
        sb.delete();
        step();
        check("t6_en", en, 8'h00);
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_steps", steps_done, 16'd0);
        check("t6_period", period_o, 256'd0);
        check("t6_dir", dir, 8'h00);
        check("t6_ready_in_rst", dut_if.cmd_ready, 1'b0);
        rst_n = 1'b1;
        step();
        check("t6_ready_after", dut_if.cmd_ready, 1'b1);
        check("t6_no_done", done_cnt, d0);

        // Normal operation after reset
        send(3'd6, 1'b1, 16'd2, 32'd66, 32'd33, mk_exp(1'b0, 1'b0, 16'd2, 8'h40, SETTLE + 1, 1'b0, -1), 1'b0);
        check("t7_period6", period_o[192 +: 32], 32'd66);
        wait_idle(2000);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwm_move_seq.md
PWM_MOVE_SEQ -- requirements
Module: pwm_move_seq

Interface
REQ-001 Parameter SETTLE_CYC, default 1000, idle cycles after a move completes before the next command is accepted.
REQ-002 Parameter TIMEOUT_CYC, default 2000000, maximum cycles allowed between step edges before a move is aborted with error.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  move command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_ch  input  3  target PWM channel 0-7.
REQ-008 cmd_dir  input  1  direction level for target channel.
REQ-009 cmd_steps  input  16  number of PWM pulses to issue.
REQ-010 cmd_period  input  32  period value for target channel.
REQ-011 cmd_duty  input  32  duty value for target channel.
REQ-012 abort  input  1  cancel the move in progress.
REQ-013 pwm_in  input  8  PWM outputs fed back from the 8-channel PWM generator.
REQ-014 en  output  8  per-channel PWM enable.
REQ-015 dir  output  8  per-channel direction level.
REQ-016 period_o  output  256  flat per-channel period, channel n at bits [32n+31:32n].
REQ-017 duty_o  output  256  flat per-channel duty, same packing.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 done  output  1  one-cycle pulse at move end.
REQ-020 aborted  output  1  valid with done: move ended by abort or timeout.
REQ-021 timeout_err  output  1  valid with done: move ended by timeout.
REQ-022 steps_done  output  16  pulses counted in current/last move.

Function
REQ-023 FSM states IDLE, LOAD, RUN, SETTLE, DONE; exactly one move in progress at a time.
REQ-024 cmd_ready = 1 only in IDLE; handshake = cmd_valid & cmd_ready; accept latches ch, dir, steps and moves to LOAD.
REQ-025 On accept, period_o/duty_o slice of cmd_ch and dir[cmd_ch] update next cycle; other slices unchanged.
REQ-026 LOAD lasts exactly 1 cycle, en all zero; then RUN if steps != 0, else DONE with aborted = 0.
REQ-027 RUN: en[ch] = 1, all other en bits 0; steps_done cleared on entry.
REQ-028 Step edge = pwm_in[ch] high this cycle and low the previous cycle (1-cycle registered history, history cleared in LOAD).
REQ-029 Each step edge increments steps_done and reloads timeout counter; when steps_done reaches steps, en[ch] drops the next cycle and state goes to SETTLE.
REQ-030 Timeout counter counts RUN cycles since last edge (or since RUN entry); reaching TIMEOUT_CYC: en cleared, go DONE with aborted = 1, timeout_err = 1.
REQ-031 abort high in LOAD, RUN or SETTLE: en cleared next cycle, go DONE with aborted = 1, timeout_err = 0; abort in IDLE/DONE ignored.
REQ-032 abort and final step edge in same cycle: abort wins.
REQ-033 SETTLE: en all zero, counts SETTLE_CYC cycles, then DONE; SETTLE_CYC = 0 means SETTLE lasts 1 cycle.
REQ-034 DONE lasts 1 cycle: done = 1, aborted/timeout_err valid; next state IDLE; aborted/timeout_err hold until next accept.
REQ-035 steps_done holds its final value until the next move enters RUN; 16-bit counter never wraps (terminates at steps).
REQ-036 Command inputs ignored when cmd_ready = 0.

Reset
REQ-037 While rst_n = 0 at posedge clk: state IDLE, en = 0, dir = 0, period_o = 0, duty_o = 0, busy = 0, done = 0, aborted = 0, timeout_err = 0, steps_done = 0, counters and edge history 0.
REQ-038 cmd_ready = 0 while rst_n = 0; 1 from first cycle after release.
REQ-039 Reset mid-move forces en = 0 next posedge with no done pulse.

Verification
REQ-040 Accept ch=3, steps=5, period=100, duty=50, pwm_in[3] driven by model -> period_o[127:96]=100, duty_o[127:96]=50, en=0x08 for exactly 5 edges, done pulse SETTLE_CYC+1 cycles after en drops, aborted=0, steps_done=5.
REQ-041 Command with steps=0 on ch=0 -> en never asserted, done 2 cycles after accept, aborted=0.
REQ-042 ch=7, steps=10, abort after 4 edges -> en=0 next cycle, done next, aborted=1, timeout_err=0, steps_done=4.
REQ-043 TIMEOUT_CYC=50, pwm_in held low -> en[ch] high 50 cycles, done with aborted=1, timeout_err=1.
REQ-044 cmd_valid held high during a move with different ch -> ignored, accepted only after return to IDLE; second move's config appears only in its own slice.
REQ-045 rst_n low during RUN -> all outputs at reset values next cycle, no done, cmd_ready=1 after release.
